// File: rtl/mem_io_responder.sv
// mem_io_responder: memory-side responder for the CPU byte-wide bus.
//   - On-chip RAM of 2**RAM_ADDR_WIDTH bytes, one access per cycle, 1-cycle read latency.
//   - IO window at mem_a[17:16]==2'b11:
//       0x30000 write: push TX FIFO     0x30000 read: RX FIFO pop (0x00 if empty/absent)
//       0x30004 write: set prog_end     0x30004 read: TX FIFO occupancy
//   - Optional receive path enabled by defining MEM_IO_RX_EN.
//
// TX handshake: tx_valid/tx_data are driven from registers; a byte is transferred on
// every rising edge where tx_valid && tx_ready. tx_data is held stable until it is
// accepted, and tx_valid never drops without a transfer (except on reset).
module mem_io_responder #(
  parameter int RAM_ADDR_WIDTH  = 17,
  parameter int FIFO_DEPTH_LOG2 = 4
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  input  logic [31:0] mem_a,
  input  logic [7:0]  mem_wdata,
  input  logic        mem_wr,
  output logic [7:0]  mem_rdata,
  output logic        io_buffer_full,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        prog_end
`ifdef MEM_IO_RX_EN
  ,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid
`endif
);

  localparam int PW = FIFO_DEPTH_LOG2;
  localparam int CW = FIFO_DEPTH_LOG2 + 1;
  localparam int DEPTH = 2 ** FIFO_DEPTH_LOG2;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);
  localparam logic [PW-1:0] PTR_ONE = PW'(1);

  // Address bits above the decoded range are intentionally ignored.
  logic unused_addr_bits;
  assign unused_addr_bits = ^mem_a[31:18];

  // ---------------------------------------------------------------------------
  // Decode
  // ---------------------------------------------------------------------------
  logic        io_sel;
  logic        off_0;
  logic        off_4;
  logic        wr_en;
  logic        rd_en;

  assign io_sel = (mem_a[17:16] == 2'b11);
  assign off_0  = (mem_a[15:0] == 16'h0000);
  assign off_4  = (mem_a[15:0] == 16'h0004);
  assign wr_en  = rdy_in &&  mem_wr;
  assign rd_en  = rdy_in && !mem_wr;

  // ---------------------------------------------------------------------------
  // RAM
  // ---------------------------------------------------------------------------
  logic [7:0] ram [2**RAM_ADDR_WIDTH];

  // RAM write port; contents are never reset.
  always_ff @(posedge clk_in) begin
    if (wr_en && !io_sel) begin
      ram[mem_a[RAM_ADDR_WIDTH-1:0]] <= mem_wdata;
    end
  end

  // ---------------------------------------------------------------------------
  // TX FIFO
  // ---------------------------------------------------------------------------
  logic [7:0]    tx_mem [DEPTH];
  logic [PW-1:0] tx_head_q, tx_head_d;
  logic [PW-1:0] tx_tail_q, tx_tail_d;
  logic [CW-1:0] tx_count_q, tx_count_d;
  logic          tx_push;
  logic          tx_pop;

  // Push decision uses the pre-edge count, so a push into a full FIFO is dropped
  // even when a pop happens in the same cycle.
  assign tx_push = wr_en && io_sel && off_0 && (tx_count_q != DEPTH_C);
  assign tx_pop  = tx_valid && tx_ready;

  // TX pointer and occupancy next-state.
  always_comb begin
    tx_head_d  = tx_head_q;
    tx_tail_d  = tx_tail_q;
    tx_count_d = tx_count_q;
    if (tx_push) begin
      tx_tail_d = tx_tail_q + PTR_ONE;
    end
    if (tx_pop) begin
      tx_head_d = tx_head_q + PTR_ONE;
    end
    if (tx_push && !tx_pop) begin
      tx_count_d = tx_count_q + CNT_ONE;
    end else if (!tx_push && tx_pop) begin
      tx_count_d = tx_count_q - CNT_ONE;
    end
  end

  // TX pointer and occupancy registers.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      tx_head_q  <= '0;
      tx_tail_q  <= '0;
      tx_count_q <= '0;
    end else begin
      tx_head_q  <= tx_head_d;
      tx_tail_q  <= tx_tail_d;
      tx_count_q <= tx_count_d;
    end
  end

  // TX storage; not reset, stale entries are unreachable once pointers clear.
  always_ff @(posedge clk_in) begin
    if (tx_push) begin
      tx_mem[tx_tail_q] <= mem_wdata;
    end
  end

  assign tx_valid       = (tx_count_q != '0);
  assign tx_data        = tx_valid ? tx_mem[tx_head_q] : 8'h00;
  assign io_buffer_full = (tx_count_q == DEPTH_C);

`ifdef MEM_IO_RX_EN
  // ---------------------------------------------------------------------------
  // RX FIFO
  // ---------------------------------------------------------------------------
  logic [7:0]    rx_mem [DEPTH];
  logic [PW-1:0] rx_head_q, rx_head_d;
  logic [PW-1:0] rx_tail_q, rx_tail_d;
  logic [CW-1:0] rx_count_q, rx_count_d;
  logic          rx_push;
  logic          rx_pop;

  assign rx_push = rx_valid && (rx_count_q != DEPTH_C);
  assign rx_pop  = rd_en && io_sel && off_0 && (rx_count_q != '0);

  // RX pointer and occupancy next-state.
  always_comb begin
    rx_head_d  = rx_head_q;
    rx_tail_d  = rx_tail_q;
    rx_count_d = rx_count_q;
    if (rx_push) begin
      rx_tail_d = rx_tail_q + PTR_ONE;
    end
    if (rx_pop) begin
      rx_head_d = rx_head_q + PTR_ONE;
    end
    if (rx_push && !rx_pop) begin
      rx_count_d = rx_count_q + CNT_ONE;
    end else if (!rx_push && rx_pop) begin
      rx_count_d = rx_count_q - CNT_ONE;
    end
  end

  // RX pointer and occupancy registers.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      rx_head_q  <= '0;
      rx_tail_q  <= '0;
      rx_count_q <= '0;
    end else begin
      rx_head_q  <= rx_head_d;
      rx_tail_q  <= rx_tail_d;
      rx_count_q <= rx_count_d;
    end
  end

  // RX storage; not reset.
  always_ff @(posedge clk_in) begin
    if (rx_push) begin
      rx_mem[rx_tail_q] <= rx_data;
    end
  end
`endif

  // ---------------------------------------------------------------------------
  // IO read mux
  // ---------------------------------------------------------------------------
  logic [7:0] io_rdata;

  // Select the IO register value for the addressed offset.
  always_comb begin
    io_rdata = 8'h00;
    if (off_0) begin
`ifdef MEM_IO_RX_EN
      if (rx_count_q != '0) begin
        io_rdata = rx_mem[rx_head_q];
      end
`endif
    end else if (off_4) begin
      io_rdata = 8'(tx_count_q);
    end
  end

  // ---------------------------------------------------------------------------
  // Registered read data and program-end flag
  // ---------------------------------------------------------------------------
  logic [7:0] mem_rdata_q;
  logic       prog_end_q;

  // Read data register: updates only on a qualifying read, otherwise holds.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      mem_rdata_q <= 8'h00;
    end else if (rd_en) begin
      if (io_sel) begin
        mem_rdata_q <= io_rdata;
      end else begin
        mem_rdata_q <= ram[mem_a[RAM_ADDR_WIDTH-1:0]];
      end
    end
  end

  // Sticky program-end flag, cleared only by reset.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      prog_end_q <= 1'b0;
    end else if (wr_en && io_sel && off_4) begin
      prog_end_q <= 1'b1;
    end
  end

  assign mem_rdata = mem_rdata_q;
  assign prog_end  = prog_end_q;

endmodule

// File: tb/tb_mem_io_responder.sv
// Directed testbench for mem_io_responder. Inputs change 1 time unit after the
// rising edge; outputs are sampled at that same point.
`timescale 1ns/1ps
module tb_mem_io_responder;

  logic        clk_in;
  logic        rst_in;
  logic        rdy_in;
  logic [31:0] mem_a;
  logic [7:0]  mem_wdata;
  logic        mem_wr;
  logic [7:0]  mem_rdata;
  logic        io_buffer_full;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic        prog_end;
`ifdef MEM_IO_RX_EN
  logic [7:0]  rx_data;
  logic        rx_valid;
`endif

  int checks = 0;
  int errors = 0;

  mem_io_responder dut (
    .clk_in         (clk_in),
    .rst_in         (rst_in),
    .rdy_in         (rdy_in),
    .mem_a          (mem_a),
    .mem_wdata      (mem_wdata),
    .mem_wr         (mem_wr),
    .mem_rdata      (mem_rdata),
    .io_buffer_full (io_buffer_full),
    .tx_data        (tx_data),
    .tx_valid       (tx_valid),
    .tx_ready       (tx_ready),
    .prog_end       (prog_end)
`ifdef MEM_IO_RX_EN
    ,
    .rx_data        (rx_data),
    .rx_valid       (rx_valid)
`endif
  );

  // Clock / reset block
  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  // ---------------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------------
  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic bus_write(input logic [31:0] addr, input logic [7:0] data);
    rdy_in    = 1'b1;
    mem_wr    = 1'b1;
    mem_a     = addr;
    mem_wdata = data;
    tick();
    rdy_in    = 1'b0;
    mem_wr    = 1'b0;
  endtask

  task automatic bus_read(input logic [31:0] addr, output logic [7:0] data);
    rdy_in = 1'b1;
    mem_wr = 1'b0;
    mem_a  = addr;
    tick();
    data   = mem_rdata;
    rdy_in = 1'b0;
  endtask

  // ---------------------------------------------------------------------------
  // Tests
  // ---------------------------------------------------------------------------
  task automatic test_reset();
    rst_in = 1'b1;
    tick();
    tick();
    rst_in = 1'b0;
    checks++; if (mem_rdata !== 8'h00) begin errors++; $display("FAIL reset_rdata got %h exp 00", mem_rdata); end
    checks++; if (io_buffer_full !== 1'b0) begin errors++; $display("FAIL reset_full got %b exp 0", io_buffer_full); end
    checks++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL reset_tx_valid got %b exp 0", tx_valid); end
    checks++; if (tx_data !== 8'h00) begin errors++; $display("FAIL reset_tx_data got %h exp 00", tx_data); end
    checks++; if (prog_end !== 1'b0) begin errors++; $display("FAIL reset_prog_end got %b exp 0", prog_end); end
  endtask

  task automatic test_ram();
    logic [7:0] rd;
    logic [7:0] exp_b [4];
    exp_b[0] = 8'h11; exp_b[1] = 8'h22; exp_b[2] = 8'h33; exp_b[3] = 8'h44;
    bus_write(32'h0001_0, 8'hA5);
    bus_read(32'h0001_0, rd);
    checks++; if (rd !== 8'hA5) begin errors++; $display("FAIL ram_rw got %h exp a5", rd); end
    for (int i = 0; i < 4; i++) bus_write(32'h10 + i, exp_b[i]);
    // Streaming reads: new address every cycle, data one cycle later.
    rdy_in = 1'b1;
    mem_wr = 1'b0;
    for (int i = 0; i < 4; i++) begin
      mem_a = 32'h10 + i;
      tick();
      checks++;
      if (mem_rdata !== exp_b[i]) begin
        errors++; $display("FAIL ram_stream[%0d] got %h exp %h", i, mem_rdata, exp_b[i]);
      end
    end
    rdy_in = 1'b0;
  endtask

  task automatic test_tx_fill();
    logic [7:0] rd;
    tx_ready = 1'b0;
    for (int i = 0; i < 16; i++) begin
      bus_write(32'h30000, 8'(i));
      if (i == 14) begin
        checks++; if (io_buffer_full !== 1'b0) begin errors++; $display("FAIL tx_full_early got %b exp 0", io_buffer_full); end
      end
    end
    checks++; if (io_buffer_full !== 1'b1) begin errors++; $display("FAIL tx_full got %b exp 1", io_buffer_full); end
    bus_read(32'h30004, rd);
    checks++; if (rd !== 8'h10) begin errors++; $display("FAIL tx_count_full got %h exp 10", rd); end
    bus_write(32'h30000, 8'hEE);
    bus_read(32'h30004, rd);
    checks++; if (rd !== 8'h10) begin errors++; $display("FAIL tx_drop_count got %h exp 10", rd); end
    tx_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      checks++;
      if (tx_valid !== 1'b1 || tx_data !== 8'(i)) begin
        errors++; $display("FAIL tx_drain[%0d] got v=%b d=%h exp v=1 d=%h", i, tx_valid, tx_data, 8'(i));
      end
      if (i == 1) begin
        checks++; if (io_buffer_full !== 1'b0) begin errors++; $display("FAIL tx_full_fall got %b exp 0", io_buffer_full); end
      end
      tick();
    end
    tx_ready = 1'b0;
    checks++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL tx_empty got %b exp 0", tx_valid); end
  endtask

  task automatic test_push_pop();
    logic [7:0] rd;
    logic [7:0] exp_q[$];
    int guard;
    tx_ready = 1'b0;
    for (int i = 0; i < 5; i++) bus_write(32'h30000, 8'h50 + 8'(i));
    bus_read(32'h30004, rd);
    checks++; if (rd !== 8'h05) begin errors++; $display("FAIL pp_count_pre got %h exp 05", rd); end
    // Pop 0x50 and push 0x55 in the same cycle.
    tx_ready = 1'b1;
    bus_write(32'h30000, 8'h55);
    tx_ready = 1'b0;
    bus_read(32'h30004, rd);
    checks++; if (rd !== 8'h05) begin errors++; $display("FAIL pp_count got %h exp 05", rd); end
    checks++; if (tx_data !== 8'h51) begin errors++; $display("FAIL pp_head got %h exp 51", tx_data); end
    // Fill to 16, then push+pop while full: push must be dropped.
    for (int i = 0; i < 11; i++) bus_write(32'h30000, 8'h60 + 8'(i));
    tx_ready = 1'b1;
    bus_write(32'h30000, 8'hEE);
    tx_ready = 1'b0;
    bus_read(32'h30004, rd);
    checks++; if (rd !== 8'h0F) begin errors++; $display("FAIL pp_full_count got %h exp 0f", rd); end
    for (int i = 0; i < 4; i++) exp_q.push_back(8'h52 + 8'(i));
    for (int i = 0; i < 11; i++) exp_q.push_back(8'h60 + 8'(i));
    tx_ready = 1'b1;
    guard = 0;
    while (tx_valid === 1'b1 && guard < 40) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++; $display("FAIL pp_drain_extra got %h exp none", tx_data);
      end else begin
        if (tx_data !== exp_q[0]) begin errors++; $display("FAIL pp_drain got %h exp %h", tx_data, exp_q[0]); end
        void'(exp_q.pop_front());
      end
      tick();
      guard++;
    end
    tx_ready = 1'b0;
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL pp_drain_left got %0d exp 0", exp_q.size()); end
  endtask

  task automatic test_rdy_low();
    logic [7:0] rd;
    bus_write(32'h20, 8'h77);
    tx_ready = 1'b0;
    bus_write(32'h30000, 8'h99);
    bus_read(32'h10, rd);
    checks++; if (rd !== 8'h11) begin errors++; $display("FAIL rdy_pre_read got %h exp 11", rd); end
    rdy_in = 1'b0; mem_wr = 1'b1; mem_a = 32'h20; mem_wdata = 8'hCC; tx_ready = 1'b1;
    tick();
    mem_wr = 1'b0; tx_ready = 1'b0;
    checks++; if (mem_rdata !== 8'h11) begin errors++; $display("FAIL rdy_hold got %h exp 11", mem_rdata); end
    checks++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL rdy_tx_pop got %b exp 0", tx_valid); end
    bus_read(32'h20, rd);
    checks++; if (rd !== 8'h77) begin errors++; $display("FAIL rdy_ram_kept got %h exp 77", rd); end
  endtask

  task automatic test_io_misc();
    logic [7:0] rd;
    bus_write(32'h30008, 8'h12);
    bus_read(32'h30004, rd);
    checks++; if (rd !== 8'h00) begin errors++; $display("FAIL io_other_wr got %h exp 00", rd); end
    bus_read(32'h30008, rd);
    checks++; if (rd !== 8'h00) begin errors++; $display("FAIL io_other_rd got %h exp 00", rd); end
    bus_read(32'h10, rd);
    bus_read(32'h30000, rd);
    checks++; if (rd !== 8'h00) begin errors++; $display("FAIL io_rx_empty got %h exp 00", rd); end
  endtask

  task automatic test_prog_end();
    logic [7:0] rd;
    checks++; if (prog_end !== 1'b0) begin errors++; $display("FAIL pe_pre got %b exp 0", prog_end); end
    bus_write(32'h30004, 8'h01);
    checks++; if (prog_end !== 1'b1) begin errors++; $display("FAIL pe_set got %b exp 1", prog_end); end
    tick();
    checks++; if (prog_end !== 1'b1) begin errors++; $display("FAIL pe_sticky got %b exp 1", prog_end); end
    tx_ready = 1'b0;
    for (int i = 0; i < 16; i++) bus_write(32'h30000, 8'hA0 + 8'(i));
    bus_read(32'h30004, rd);
    checks++; if (rd !== 8'h10 || io_buffer_full !== 1'b1) begin errors++; $display("FAIL pe_fill got %h/%b exp 10/1", rd, io_buffer_full); end
    rst_in = 1'b1;
    tick();
    rst_in = 1'b0;
    checks++; if (prog_end !== 1'b0) begin errors++; $display("FAIL rst_prog_end got %b exp 0", prog_end); end
    checks++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL rst_tx_valid got %b exp 0", tx_valid); end
    checks++; if (io_buffer_full !== 1'b0) begin errors++; $display("FAIL rst_full got %b exp 0", io_buffer_full); end
    checks++; if (mem_rdata !== 8'h00) begin errors++; $display("FAIL rst_rdata got %h exp 00", mem_rdata); end
  endtask

`ifdef MEM_IO_RX_EN
  task automatic test_rx();
    logic [7:0] rd;
    rx_valid = 1'b1; rx_data = 8'h41; tick();
    rx_data = 8'h42; tick();
    rx_valid = 1'b0;
    bus_read(32'h30000, rd);
    checks++; if (rd !== 8'h41) begin errors++; $display("FAIL rx_first got %h exp 41", rd); end
    bus_read(32'h30000, rd);
    checks++; if (rd !== 8'h42) begin errors++; $display("FAIL rx_second got %h exp 42", rd); end
    bus_read(32'h30000, rd);
    checks++; if (rd !== 8'h00) begin errors++; $display("FAIL rx_empty got %h exp 00", rd); end
  endtask
`endif

  // Main sequence and final report
  initial begin
    rst_in = 1'b1; rdy_in = 1'b0; mem_a = '0; mem_wdata = '0; mem_wr = 1'b0; tx_ready = 1'b0;
`ifdef MEM_IO_RX_EN
    rx_data = '0; rx_valid = 1'b0;
`endif
    test_reset();
    test_ram();
    test_tx_fill();
    test_push_pop();
    test_rdy_low();
    test_io_misc();
`ifdef MEM_IO_RX_EN
    test_rx();
`endif
    test_prog_end();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_io_responder.md
# mem_io_responder

Memory-side responder for the CPU's byte-wide memory bus. Serves one byte per cycle from on-chip RAM, and decodes an IO window at addresses with `mem_a[17:16]==2'b11`. The IO window holds a UART transmit FIFO, a program-end flag and, optionally, a receive FIFO. The block drives `io_buffer_full` back to the CPU-side memory adapter, which must not issue an IO write while the flag is high.

## Interface
Parameters:
- `RAM_ADDR_WIDTH`, default 17: RAM holds 2^17 bytes, indexed by `mem_a[RAM_ADDR_WIDTH-1:0]`.
- `FIFO_DEPTH_LOG2`, default 4: TX (and RX) FIFO depth is 16 entries.

Ports:
- `clk_in` in 1: system clock. The block has one clock; all logic is on its rising edge.
- `rst_in` in 1: reset, synchronous and active-high.
- `rdy_in` in 1: bus accesses are ignored when this is low.
- `mem_a` in 32: byte address. Only bits 17:0 are decoded.
- `mem_wdata` in 8: write data (the adapter's `mem_dout`).
- `mem_wr` in 1: 1 = write, 0 = read.
- `mem_rdata` out 8: read data (the adapter's `mem_din`).
- `io_buffer_full` out 1: TX FIFO is full.
- `tx_data` out 8: head byte of the TX FIFO.
- `tx_valid` out 1: TX FIFO is non-empty.
- `tx_ready` in 1: the sink accepts the head byte.
- `prog_end` out 1: sticky flag, set when the program signals its end.
- `rx_data` in 8 and `rx_valid` in 1: present only with `MEM_IO_RX_EN`.

## Operation
- Address decode: `io_sel = (mem_a[17:16]==2'b11)`. RAM is selected otherwise.
- RAM write: when `rdy_in && mem_wr && !io_sel`, `ram[mem_a[RAM_ADDR_WIDTH-1:0]] <= mem_wdata`.
- RAM read: when `rdy_in && !mem_wr && !io_sel`, `mem_rdata <= ram[addr]` (registered). A read and a write to the same address in the same cycle cannot occur, because a single port carries one access per cycle.
- IO write to offset 0 (`0x30000`): pushes `mem_wdata` into the TX FIFO. A push while the FIFO is full is dropped and the FIFO is unchanged.
- IO write to offset 4 (`0x30004`): sets `prog_end` to 1. It stays set until reset.
- IO writes to any other offset are ignored.
- IO read from offset 0:
  - With `MEM_IO_RX_EN`: returns the RX FIFO head and pops it.
  - With RX empty, or without the macro: returns `0x00`.
- IO read from offset 4: returns `{{(8-FIFO_DEPTH_LOG2-1){1'b0}}, tx_count}`.
- IO reads from any other offset return `0x00`.
- `mem_rdata` holds its previous value in any cycle without a qualifying read, including whenever `rdy_in` is low.
- TX drain:
  - `tx_valid = (tx_count != 0)`, `tx_data = fifo[head]`.
  - Pop when `tx_valid && tx_ready`.
  - Drain does not depend on `rdy_in`.
- Simultaneous push and pop: `tx_count` is unchanged and both pointers advance. When the FIFO is full, a same-cycle push is still dropped (the push check uses the pre-edge count).
- Pointers are `FIFO_DEPTH_LOG2` bits wide and wrap modulo the depth. `tx_count` is `FIFO_DEPTH_LOG2+1` bits wide, range 0..DEPTH.
- `io_buffer_full = (tx_count == 2**FIFO_DEPTH_LOG2)`, decoded from registers only. There is no combinational path from any input.

## Timing
- Read latency is 1 cycle. The address presented in cycle N yields `mem_rdata` valid after edge N+1, which is when the adapter samples it in cycle N+1. Back-to-back reads at consecutive addresses stream one byte per cycle.
- A write commits at the edge that ends the cycle in which `mem_wr` is high.
- A TX push in cycle N makes `tx_valid` high from cycle N+1.
- `io_buffer_full` rises in the cycle after the push that fills the FIFO. It falls in the cycle after the first pop.
- Reset values: `mem_rdata=0`, `io_buffer_full=0`, `tx_valid=0`, `tx_data=0` (FIFO storage is not reset; `tx_data` reads 0 because it is masked while empty), `prog_end=0`, FIFO pointers and counts 0. RAM contents are not reset.
- Reset mid-operation: all FIFO contents are discarded immediately, and an in-flight read returns 0.

## Configuration
- `MEM_IO_RX_EN` defined:
  - Adds the `rx_data`/`rx_valid` ports and an RX FIFO of the same depth.
  - `rx_valid` pushes `rx_data` into the RX FIFO; the push is dropped if the RX FIFO is full.
  - An IO read from offset 0 pops the RX FIFO and returns the popped byte.
  - A same-cycle push and pop are both honoured.
- `MEM_IO_RX_EN` undefined: no RX ports and no RX storage; an IO read from offset 0 returns `0x00`.

## Test plan
- RAM byte write/read: write `0xA5` to `0x00010`, then read `0x00010` -> `mem_rdata=0xA5` one cycle later. Reads of `0x10..0x13` after writing `11 22 33 44` stream `11 22 33 44` on consecutive cycles.
- TX fill to full:
  - With `tx_ready=0`, write 16 bytes `0x00..0x0F` to `0x30000` -> `io_buffer_full=1` one cycle after the 16th write.
  - A 17th write is dropped.
  - Raise `tx_ready` -> `tx_data` sequence is `0x00..0x0F`, then `tx_valid=0`.
- Simultaneous push and pop with count 5 -> count stays 5, and an IO read of `0x30004` returns `0x05`.
- `rdy_in=0` during a RAM write to `0x00020` -> RAM unchanged and `mem_rdata` held. A TX pop still occurs when `tx_ready=1`.
- Program end: write to `0x30004` -> `prog_end=1` from the next cycle. Assert `rst_in` -> `prog_end=0`, `tx_valid=0`, `io_buffer_full=0`.
- `MEM_IO_RX_EN`: push `0x41`, `0x42` via `rx_valid`, then read `0x30000` twice -> `0x41`, `0x42`. A third read returns `0x00`.
